iterative_multiplier_unit: RTL
==============================

ITERATIVE_MULTIPLIER_UNIT -- requirements
Module: iterative_multiplier_unit

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width in bits (W >= 4, even).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset_asynchronous_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: inp_start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port: inp_flush  input  1  synchronous abort of any operation in flight.
REQ-006 SHALL have port: inp_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have ports: inp_operand0 and inp_operand1, each input, W bits, the two register-file read-data values.
REQ-008 SHALL have port: inp_dest_address  input  4  register-file destination index.
REQ-009 SHALL have port: out_busy  output  1  high in RUN and DONE.
REQ-010 SHALL have port: out_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports: out_result_low and out_result_high, each output, W bits, product bits [W-1:0] and [2W-1:W].
REQ-012 SHALL have port: out_write_address  output  4  captured destination, driven to the register-file write address.
REQ-013 SHALL have port: out_write_enable  output  1  register-file write strobe for out_result_low.
REQ-014 SHALL have port: out_error  output  1  one-cycle pulse for an illegal destination.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 SHALL go IDLE->RUN when inp_start=1 and inp_flush=0, capturing operands, inp_signed and inp_dest_address on that edge.
REQ-017 SHALL, in signed mode, capture magnitudes and a negate flag equal to the XOR of the operand sign bits.
REQ-018 SHALL execute one shift-add step per cycle in RUN using a W-bit multiplicand, a 2W-bit accumulator and a down-counter loaded with W-1.
REQ-019 SHALL go RUN->DONE on the cycle the counter reaches 0, after exactly W RUN cycles.
REQ-020 SHALL give fixed latency: out_done is high exactly W+1 cycles after the edge that accepts start, with no early termination.
REQ-021 SHALL, in DONE, assert out_done for one cycle, present the final 2W-bit product (two's-complement negated if the flag is set) and return to IDLE.
REQ-022 SHALL hold out_result_* stable from DONE until the next accepted start.
REQ-023 SHALL assert out_write_enable only in DONE and only when the captured destination is not 15.
REQ-024 SHALL, when the captured destination is 15, keep out_write_enable=0 and assert out_error together with out_done.
REQ-025 SHALL ignore inp_start in RUN and DONE; such a request is not queued.
REQ-026 SHALL, on inp_flush=1 in any state, enter IDLE on the next edge with no out_done, out_write_enable or out_error pulse; flush wins over a simultaneous start.
REQ-027 SHALL compute operand 0 x 0, -2^(W-1) x -2^(W-1) and all-ones x all-ones exactly, with no overflow flag because the 2W-bit result is exact.

Reset
REQ-028 SHALL, while reset_asynchronous_n=0, immediately force IDLE and set every output, the accumulator and the counter to 0.
REQ-029 SHALL abandon an in-flight operation on reset with no write; after reset release the next start behaves as from power-up.

Structure
REQ-030 SHALL take the state encoding (IDLE=0, RUN=1, DONE=2), the default W and the R15 index constant from a shared package.
REQ-031 SHALL place the accumulator, adder and shifter in one sub-module, shift_add_datapath, with the FSM and counter in the top level.

Verification
REQ-032 SHALL cover unsigned 6 x 7, destination 3: low=42, high=0, out_done and out_write_enable at cycle W+1=33, out_write_address=3.
REQ-033 SHALL cover signed -3 (0xFFFFFFFD) x 5: low=0xFFFFFFF1, high=0xFFFFFFFF.
REQ-034 SHALL cover unsigned 0xFFFFFFFF x 0xFFFFFFFF: low=0x00000001, high=0xFFFFFFFE; the same operands signed give low=1, high=0.
REQ-035 SHALL cover a start at cycle 10 of RUN with new operands: ignored, the first result is unchanged and only one out_done pulse occurs.
REQ-036 SHALL cover destination 15: out_error=1, out_write_enable=0 and out_done=1 in the same cycle.
REQ-037 SHALL cover reset at RUN cycle 5, and separately a flush at RUN cycle 5: both reach IDLE with no write, then 2 x 2 completes with low=4.

Source files
------------

// File: rtl/iterative_multiplier_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encoding,
// default operand width and the reserved register index.
package iterative_multiplier_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int          W_DEFAULT = 32;
  localparam logic [3:0]  R15_IDX   = 4'd15;

endpackage

// File: rtl/iterative_multiplier_unit_datapath.sv
// Radix-2 shift-add core: W-bit multiplicand, 2W-bit accumulator whose low
// half starts as the multiplier and drains one bit per step.
module shift_add_datapath
  import iterative_multiplier_unit_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   mcand_in,
  input  logic [W-1:0]   mplier_in,
  output logic [2*W-1:0] acc_step
);

  logic [W-1:0]   mcand_d, mcand_q;
  logic [2*W-1:0] acc_d, acc_q;
  logic [W:0]     sum;

  // Carry out of the upper-half add becomes the new MSB after the shift.
  always_comb begin
    sum      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {sum, acc_q[W-1:1]};
  end

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (load) begin
      mcand_d = mcand_in;
      acc_d   = {{W{1'b0}}, mplier_in};
    end else if (step) begin
      acc_d   = acc_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/iterative_multiplier_unit.sv
// Fixed-latency iterative multiplier with register-file writeback: sign
// handling, step counter and FSM here, arithmetic in shift_add_datapath.
module iterative_multiplier_unit
  import iterative_multiplier_unit_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_asynchronous_n,
  input  logic         inp_start,
  input  logic         inp_flush,
  input  logic         inp_signed,
  input  logic [W-1:0] inp_operand0,
  input  logic [W-1:0] inp_operand1,
  input  logic [3:0]   inp_dest_address,
  output logic         out_busy,
  output logic         out_done,
  output logic [W-1:0] out_result_low,
  output logic [W-1:0] out_result_high,
  output logic [3:0]   out_write_address,
  output logic         out_write_enable,
  output logic         out_error
);

  localparam int CW = $clog2(W);

  state_e         state_d, state_q;
  logic [CW-1:0]  cnt_d, cnt_q;
  logic           neg_d, neg_q;
  logic [3:0]     dest_d, dest_q;
  logic           busy_d, busy_q;
  logic           done_d, done_q;
  logic           we_d, we_q;
  logic           err_d, err_q;
  logic [W-1:0]   res_lo_d, res_lo_q, res_hi_d, res_hi_q;

  logic           dp_load, dp_step;
  logic [W-1:0]   mag0, mag1;
  logic [2*W-1:0] dp_acc_step, product;

  // Magnitudes fit in W unsigned bits, including -2^(W-1).
  always_comb begin
    mag0    = (inp_signed && inp_operand0[W-1]) ? -inp_operand0 : inp_operand0;
    mag1    = (inp_signed && inp_operand1[W-1]) ? -inp_operand1 : inp_operand1;
    product = neg_q ? -dp_acc_step : dp_acc_step;
  end

  shift_add_datapath #(.W(W)) u_dp (
    .clk       (clk),
    .rst_n     (reset_asynchronous_n),
    .load      (dp_load),
    .step      (dp_step),
    .mcand_in  (mag0),
    .mplier_in (mag1),
    .acc_step  (dp_acc_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    dest_d   = dest_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    err_d    = 1'b0;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inp_start) begin
          state_d = ST_RUN;
          cnt_d   = CW'(W - 1);
          neg_d   = inp_signed & (inp_operand0[W-1] ^ inp_operand1[W-1]);
          dest_d  = inp_dest_address;
          dp_load = 1'b1;
        end
      end
      ST_RUN: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          done_d   = 1'b1;
          we_d     = (dest_q != R15_IDX);
          err_d    = (dest_q == R15_IDX);
          res_lo_d = product[W-1:0];
          res_hi_d = product[2*W-1:W];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything, including a start seen in the same cycle.
    if (inp_flush) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      we_d     = 1'b0;
      err_d    = 1'b0;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      dp_load  = 1'b0;
      dp_step  = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_asynchronous_n) begin
    if (!reset_asynchronous_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      dest_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      dest_q   <= dest_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      err_q    <= err_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign out_busy          = busy_q;
  assign out_done          = done_q;
  assign out_write_enable  = we_q;
  assign out_error         = err_q;
  assign out_write_address = dest_q;
  assign out_result_low    = res_lo_q;
  assign out_result_high   = res_hi_q;

endmodule
